// File: rtl/f2a_link_rx_if.sv
// Bundle of the F2A serial lanes, the A2F ack line, the valid/ready word
// output and the sticky error flags of the F2A link receiver.
interface f2a_link_rx_if #(
   parameter int DATA_W = 8
);
   logic              f2a_data_i;
   logic              f2a_frame_i;
   logic              a2f_ack_o;
   logic [DATA_W-1:0] m_data_o;
   logic              m_valid_o;
   logic              m_ready_i;
   logic              err_parity_o;
   logic              err_frame_o;
   logic              err_ovf_o;
   logic              err_clr_i;

   modport slave (
      input  f2a_data_i, f2a_frame_i, m_ready_i, err_clr_i,
      output a2f_ack_o, m_data_o, m_valid_o, err_parity_o, err_frame_o, err_ovf_o
   );

   modport master (
      output f2a_data_i, f2a_frame_i, m_ready_i, err_clr_i,
      input  a2f_ack_o, m_data_o, m_valid_o, err_parity_o, err_frame_o, err_ovf_o
   );
endinterface

// File: rtl/f2a_link_rx.sv
// ASIC-side receiver of the fabric F2A serial link: deserialises framed,
// even-parity words into a valid/ready holding register and acks each word.
module f2a_link_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   f2a_link_rx_if.slave  bus
);
   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   function automatic logic parity_even_ok(input logic [DATA_W-1:0] d, input logic p);
      return ((^d) ^ p) == 1'b0;
   endfunction

   logic w_fd;
   logic w_ff;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_fd = bus.f2a_data_i;
         assign w_ff = bus.f2a_frame_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync_d;
         logic [SYNC_STAGES-1:0] r_sync_f;

         // Lane synchroniser chains.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_sync_d <= '0;
               r_sync_f <= '0;
            end else begin
               r_sync_d[0] <= bus.f2a_data_i;
               r_sync_f[0] <= bus.f2a_frame_i;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  r_sync_d[i] <= r_sync_d[i-1];
                  r_sync_f[i] <= r_sync_f[i-1];
               end
            end
         end

         assign w_fd = r_sync_d[SYNC_STAGES-1];
         assign w_ff = r_sync_f[SYNC_STAGES-1];
      end
   endgenerate

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_drain_err;
   logic              r_ack;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_err_par;
   logic              r_err_frm;
   logic              r_err_ovf;

   logic w_par_cycle;
   logic w_par_good;
   logic w_load;
   logic w_set_par;
   logic w_set_frm;
   logic w_set_ovf;

   // Commit decision and error-set strobes for the current FSM cycle.
   always_comb begin
      w_par_cycle = (r_state == ST_PARITY) && w_ff;
      w_par_good  = w_par_cycle && parity_even_ok(r_shift, w_fd);
      w_load      = w_par_good && (!r_valid || bus.m_ready_i);
      w_set_par   = w_par_cycle && !w_par_good;
      w_set_ovf   = w_par_good && !w_load;
      w_set_frm   = 1'b0;
      case (r_state)
         ST_DATA, ST_PARITY: w_set_frm = !w_ff;
         ST_DRAIN:           w_set_frm = w_ff && !r_drain_err;
         default:            w_set_frm = 1'b0;
      endcase
   end

   // Frame FSM: bit capture, parity slot and overlong-frame drain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_drain_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_ff) begin
                  r_shift <= {{(DATA_W-1){1'b0}}, w_fd};
                  r_cnt   <= CNT_W'(1);
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_ff) begin
                  r_shift[r_cnt] <= w_fd;
                  if (r_cnt == CNT_LAST) begin
                     r_state <= ST_PARITY;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_PARITY: begin
               r_drain_err <= 1'b0;
               r_state     <= w_ff ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
               if (w_ff) begin
                  r_drain_err <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Holding register, ack pulse and sticky errors (a set beats a clear).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ack     <= 1'b0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_err_par <= 1'b0;
         r_err_frm <= 1'b0;
         r_err_ovf <= 1'b0;
      end else begin
         r_ack <= w_load;
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && bus.m_ready_i) begin
            r_valid <= 1'b0;
         end
         r_err_par <= w_set_par | (r_err_par & ~bus.err_clr_i);
         r_err_frm <= w_set_frm | (r_err_frm & ~bus.err_clr_i);
         r_err_ovf <= w_set_ovf | (r_err_ovf & ~bus.err_clr_i);
      end
   end

   assign bus.a2f_ack_o    = r_ack;
   assign bus.m_valid_o    = r_valid;
   assign bus.m_data_o     = r_data;
   assign bus.err_parity_o = r_err_par;
   assign bus.err_frame_o  = r_err_frm;
   assign bus.err_ovf_o    = r_err_ovf;
endmodule

// File: tb/tb_f2a_link_rx.sv
// Scoreboard bench for f2a_link_rx (DATA_W=8, SYNC_STAGES=2): directed frames
// push expected words; a negedge monitor pops and compares on each handshake.
module tb_f2a_link_rx;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   f2a_link_rx_if #(.DATA_W(8)) bus ();

   f2a_link_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ack_cnt = 0;
   int exp_ack_cyc = -1;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: counts acks, checks ack latency once armed, scores handshaken words.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.a2f_ack_o) begin
            ack_cnt++;
            if (exp_ack_cyc >= 0) begin
               check("ack_latency", cyc, exp_ack_cyc);
               exp_ack_cyc = -1;
            end
         end
         if (bus.m_valid_o && bus.m_ready_i) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_word: got 0x%0h, expected none", bus.m_data_o);
            end else begin
               mon_exp = exp_q.pop_front();
               check("word", {24'd0, bus.m_data_o}, {24'd0, mon_exp});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         bus.f2a_frame_i = 1'b0;
         bus.f2a_data_i  = 1'b0;
      end
   endtask

   // Drives nbits frame cycles (data LSB first, then parity); no trailing gap.
   task automatic send_frame(input logic [7:0] d, input logic flip, input int nbits, output int pcyc);
      for (int i = 0; i < nbits; i++) begin
         tick();
         bus.f2a_frame_i = 1'b1;
         bus.f2a_data_i  = (i < 8) ? d[i] : ((^d) ^ flip);
      end
      pcyc = cyc;
   endtask

   task automatic clear_errs();
      tick();
      bus.err_clr_i = 1'b1;
      tick();
      bus.err_clr_i = 1'b0;
   endtask

   task automatic check_errs(input string name, input logic [2:0] exp);
      check(name, {29'd0, bus.err_parity_o, bus.err_frame_o, bus.err_ovf_o}, {29'd0, exp});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, {31'd0, bus.m_valid_o}, 32'd0);
      check({tag, "_ack"},   {31'd0, bus.a2f_ack_o}, 32'd0);
      check({tag, "_data"},  {24'd0, bus.m_data_o}, 32'd0);
      check_errs({tag, "_errs"}, 3'b000);
   endtask

   initial begin
      int p;
      int a0;
      logic [7:0] d;
      bus.f2a_data_i  = 1'b0;
      bus.f2a_frame_i = 1'b0;
      bus.m_ready_i   = 1'b0;
      bus.err_clr_i   = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      tick();
      rst_n = 1'b1;
      idle(12);

      // Good word 0xA5, even parity, consumer ready.
      bus.m_ready_i = 1'b1;
      a0 = ack_cnt;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 9, p);
      exp_ack_cyc = p + 3;
      idle(8);
      check("a5_acks", ack_cnt - a0, 1);
      check("a5_drained", exp_q.size(), 0);
      check("a5_valid_low", {31'd0, bus.m_valid_o}, 32'd0);
      check_errs("a5_errs", 3'b000);

      // Parity error on 0x3C, then clear.
      a0 = ack_cnt;
      send_frame(8'h3C, 1'b1, 9, p);
      idle(8);
      check_errs("par_errs", 3'b100);
      check("par_acks", ack_cnt - a0, 0);
      check("par_valid", {31'd0, bus.m_valid_o}, 32'd0);
      clear_errs();
      check_errs("par_cleared", 3'b000);

      // Short frame (5 bits) followed by good 0x01.
      a0 = ack_cnt;
      send_frame(8'h55, 1'b0, 5, p);
      idle(1);
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b0, 9, p);
      idle(8);
      check_errs("short_errs", 3'b010);
      check("short_acks", ack_cnt - a0, 1);
      check("short_drained", exp_q.size(), 0);
      clear_errs();

      // Overflow: consumer stalled, second word dropped.
      bus.m_ready_i = 1'b0;
      a0 = ack_cnt;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b0, 9, p);
      idle(1);
      send_frame(8'h22, 1'b0, 9, p);
      idle(8);
      check("ovf_data", {24'd0, bus.m_data_o}, 32'h11);
      check("ovf_valid", {31'd0, bus.m_valid_o}, 32'd1);
      check_errs("ovf_errs", 3'b001);
      check("ovf_acks", ack_cnt - a0, 1);
      bus.m_ready_i = 1'b1;
      idle(2);
      check("ovf_drained", exp_q.size(), 0);
      clear_errs();

      // Rerun with ready raised exactly for the 0x22 commit edge.
      bus.m_ready_i = 1'b0;
      a0 = ack_cnt;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b0, 9, p);
      idle(1);
      exp_q.push_back(8'h22);
      send_frame(8'h22, 1'b0, 9, p);
      idle(1);
      tick();
      bus.m_ready_i = 1'b1;
      tick();
      bus.m_ready_i = 1'b0;
      idle(4);
      check("same_data", {24'd0, bus.m_data_o}, 32'h22);
      check("same_valid", {31'd0, bus.m_valid_o}, 32'd1);
      check_errs("same_errs", 3'b000);
      check("same_acks", ack_cnt - a0, 2);
      check("same_pending", exp_q.size(), 1);
      bus.m_ready_i = 1'b1;
      idle(2);
      check("same_drained", exp_q.size(), 0);

      // 16 back-to-back frames with one-cycle gaps.
      a0 = ack_cnt;
      for (int i = 0; i < 16; i++) begin
         d = 8'($urandom);
         exp_q.push_back(d);
         send_frame(d, 1'b0, 9, p);
         idle(1);
      end
      idle(8);
      check("b2b_acks", ack_cnt - a0, 16);
      check("b2b_drained", exp_q.size(), 0);
      check_errs("b2b_errs", 3'b000);

      // Reset in the middle of a frame while a word is held.
      bus.m_ready_i = 1'b0;
      exp_q.push_back(8'h77);
      send_frame(8'h77, 1'b0, 9, p);
      idle(8);
      check("pre_rst_valid", {31'd0, bus.m_valid_o}, 32'd1);
      send_frame(8'hF0, 1'b0, 4, p);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      exp_q.delete();
      bus.f2a_frame_i = 1'b0;
      bus.f2a_data_i  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      idle(12);
      bus.m_ready_i = 1'b1;
      a0 = ack_cnt;
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b0, 9, p);
      idle(8);
      check("ff_acks", ack_cnt - a0, 1);
      check("ff_drained", exp_q.size(), 0);
      check_errs("ff_errs", 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
